// File: rtl/shared_wire_arbiter_pkg.sv
// Shared types and helpers for the shared-wire arbiter and its pick logic.
package shared_wire_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    // Index width for n requesters, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shared_wire_arbiter_if.sv
// Requester-side bundle of the shared-wire arbiter: requests, data and grant status.
interface shared_wire_arbiter_if
    import shared_wire_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = idx_w(N_REQ)
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] din;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_id;
    logic             busy;
    logic             wire_out;
    logic             timeout;

    modport master (
        output req, din,
        input  gnt, gnt_id, busy, wire_out, timeout
    );

    modport slave (
        input  req, din,
        output gnt, gnt_id, busy, wire_out, timeout
    );
endinterface

// File: rtl/shared_wire_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set request scanning from ptr upward, wrapping.
module rr_priority_pick
    import shared_wire_arbiter_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);
    int unsigned      pos;
    logic [IDX_W-1:0] pos_idx;

    // Scan offsets high to low so the smallest offset from ptr wins.
    always_comb begin
        any     = |req;
        idx     = '0;
        pos     = 0;
        pos_idx = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_idx = IDX_W'(pos);
            if (req[pos_idx]) begin
                idx = pos_idx;
            end
        end
    end
endmodule

// File: rtl/shared_wire_arbiter.sv
// Round-robin arbiter sharing one registered output wire between N_REQ requesters,
// with a hold limit that force-releases a requester after MAX_HOLD grant cycles.
module shared_wire_arbiter
    import shared_wire_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned MAX_HOLD = 16,
    parameter logic        IDLE_VAL = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    shared_wire_arbiter_if.slave bus
);
    localparam int unsigned IDX_W  = idx_w(N_REQ);
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD);

    arb_state_t       state_q, state_n;
    logic [IDX_W-1:0] ptr_q, ptr_n;
    logic [HOLD_W-1:0] hold_q, hold_n;
    logic [N_REQ-1:0] gnt_q, gnt_n;
    logic [IDX_W-1:0] gnt_id_q, gnt_id_n;
    logic             busy_q, busy_n;
    logic             wire_q, wire_n;
    logic             timeout_q, timeout_n;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] ptr_after_c;
    logic             owner_req_c;

    rr_priority_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign owner_req_c = bus.req[gnt_id_q];
    assign ptr_after_c = (gnt_id_q == IDX_W'(N_REQ - 1)) ? '0 : IDX_W'(gnt_id_q + 1'b1);

    // Next-state and next-output logic; every output leaves through a register.
    always_comb begin
        state_n   = state_q;
        ptr_n     = ptr_q;
        hold_n    = hold_q;
        gnt_n     = gnt_q;
        gnt_id_n  = gnt_id_q;
        busy_n    = busy_q;
        wire_n    = wire_q;
        timeout_n = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_n  = ST_GRANT;
                    gnt_n    = N_REQ'(1) << pick_idx;
                    gnt_id_n = pick_idx;
                    busy_n   = 1'b1;
                    hold_n   = '0;
                end
            end
            ST_GRANT: begin
                // A req drop on the expiry edge is a normal release, not a timeout.
                if (!owner_req_c || (hold_q == HOLD_W'(MAX_HOLD - 1))) begin
                    state_n   = ST_RELEASE;
                    gnt_n     = '0;
                    busy_n    = 1'b0;
                    wire_n    = IDLE_VAL;
                    timeout_n = owner_req_c;
                end else begin
                    hold_n = HOLD_W'(hold_q + 1'b1);
                    wire_n = bus.din[gnt_id_q];
                end
            end
            ST_RELEASE: begin
                state_n = ST_IDLE;
                ptr_n   = ptr_after_c;
            end
            default: begin
                state_n = ST_IDLE;
                gnt_n   = '0;
                busy_n  = 1'b0;
                wire_n  = IDLE_VAL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            wire_q    <= IDLE_VAL;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            ptr_q     <= ptr_n;
            hold_q    <= hold_n;
            gnt_q     <= gnt_n;
            gnt_id_q  <= gnt_id_n;
            busy_q    <= busy_n;
            wire_q    <= wire_n;
            timeout_q <= timeout_n;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.gnt_id   = gnt_id_q;
    assign bus.busy     = busy_q;
    assign bus.wire_out = wire_q;
    assign bus.timeout  = timeout_q;
endmodule
